// File: rtl/vp_pkg.sv
// rtl/vp_pkg.sv - shared types and slicing helpers for the stride value predictor
// Contents: ADDR_WIDTH/DATA_WIDTH, table entry (vp_entry_t), pending-load entry
// (vp_qentry_t), conf_max() for the CONF_MAX localparam, vp_index()/vp_tag().
// The tag field is sized for the narrowest index so any INDEX_WIDTH fits; bits
// above the real tag stay zero and still take part in the compare.
package vp_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int CONF_FIELD_WIDTH = 8;

  typedef struct packed {
    logic                        valid;
    logic [ADDR_WIDTH-3:0]       tag;
    logic [DATA_WIDTH-1:0]       last;
    logic [DATA_WIDTH-1:0]       stride;
    logic [CONF_FIELD_WIDTH-1:0] conf;
  } vp_entry_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
    logic [DATA_WIDTH-1:0] value;
  } vp_qentry_t;

  function automatic logic [CONF_FIELD_WIDTH-1:0] conf_max(input int conf_width);
    return CONF_FIELD_WIDTH'((1 << conf_width) - 1);
  endfunction

  // Word-aligned PC: index skips the two byte-offset bits.
  function automatic logic [ADDR_WIDTH-1:0] vp_index(input logic [ADDR_WIDTH-1:0] pc,
                                                     input int index_width);
    return (pc >> 2) & ((ADDR_WIDTH'(1) << index_width) - ADDR_WIDTH'(1));
  endfunction

  function automatic logic [ADDR_WIDTH-3:0] vp_tag(input logic [ADDR_WIDTH-1:0] pc,
                                                   input int index_width);
    return (ADDR_WIDTH-2)'(pc >> (index_width + 2));
  endfunction

endpackage

// File: rtl/vp_pending_queue.sv
// rtl/vp_pending_queue.sv - in-order circular FIFO of outstanding predicted loads
// Ports: clk, rst_n (async active-low); push/push_data enqueue; pop dequeues head;
// clear empties the queue and wins over push/pop; full, empty, head (oldest entry).
module vp_pending_queue
  import vp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  vp_qentry_t push_data,
  input  logic       pop,
  input  logic       clear,
  output logic       full,
  output logic       empty,
  output vp_qentry_t head
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  vp_qentry_t           mem_q [DEPTH];
  vp_qentry_t           mem_d [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 do_push, do_pop;

  always_comb begin
    full     = (count_q == CNT_WIDTH'(DEPTH));
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/stride_value_predictor.sv
// rtl/stride_value_predictor.sv - PC-indexed last+stride load value predictor
// Ports: pred_req/pred_pc/pred_ready request side; pred_valid/pred_value one
// cycle after acceptance; resolve_valid/resolve_data check the oldest load;
// flush drops pending loads; recover/recover_pc and done report the outcome
// one cycle after the resolve; stat_* performance counters.
// Build option: define VP_STATS_EN to implement the stat counters (else tied 0).
module stride_value_predictor
  import vp_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int CONF_WIDTH  = 2,
  parameter int CONF_THRESH = 2,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  output logic                  pred_ready,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_value,
  input  logic                  resolve_valid,
  input  logic [DATA_WIDTH-1:0] resolve_data,
  input  logic                  flush,
  output logic                  recover,
  output logic [ADDR_WIDTH-1:0] recover_pc,
  output logic                  done,
  output logic [31:0]           stat_pred,
  output logic [31:0]           stat_correct,
  output logic [31:0]           stat_mispred
);

  localparam int                          ENTRIES  = 1 << INDEX_WIDTH;
  localparam logic [CONF_FIELD_WIDTH-1:0] CONF_MAX = conf_max(CONF_WIDTH);
  localparam logic [CONF_FIELD_WIDTH-1:0] THRESH   = CONF_FIELD_WIDTH'(CONF_THRESH);

  vp_entry_t             table_q [ENTRIES];
  vp_entry_t             table_d [ENTRIES];
  logic                  pred_valid_q, pred_valid_d;
  logic [DATA_WIDTH-1:0] pred_value_q, pred_value_d;
  logic                  done_q, done_d;
  logic                  recover_q, recover_d;
  logic [ADDR_WIDTH-1:0] recover_pc_q, recover_pc_d;

  logic                  q_push, q_pop, q_clear, q_full, q_empty;
  vp_qentry_t            q_push_data, q_head;

  logic [INDEX_WIDTH-1:0] lk_idx, tr_idx;
  vp_entry_t              lk_entry, tr_entry;
  logic [ADDR_WIDTH-3:0]  tr_tag;
  logic                   lk_pred;
  logic [DATA_WIDTH-1:0]  lk_value, new_stride;
  logic                   res_fire, res_match, mispredict, accept, issue;

  vp_pending_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .clear     (q_clear),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  always_comb begin
    // Lookup reads the table as it stood before this cycle's training write.
    lk_idx   = INDEX_WIDTH'(vp_index(pred_pc, INDEX_WIDTH));
    lk_entry = table_q[lk_idx];
    lk_pred  = lk_entry.valid && (lk_entry.tag == vp_tag(pred_pc, INDEX_WIDTH)) &&
               (lk_entry.conf >= THRESH);
    lk_value = lk_entry.last + lk_entry.stride;

    res_fire   = resolve_valid && !q_empty;
    res_match  = (q_head.value == resolve_data);
    mispredict = res_fire && !flush && q_head.pred && !res_match;

    // A mispredict squashes everything younger, including a same-cycle request.
    pred_ready = rst_n && !q_full && !mispredict;
    accept     = pred_req && pred_ready;
    issue      = accept && !flush;

    q_push      = issue;
    q_push_data = '{pc: pred_pc, pred: lk_pred, value: lk_value};
    q_pop       = res_fire;
    q_clear     = flush || mispredict;

    tr_idx     = INDEX_WIDTH'(vp_index(q_head.pc, INDEX_WIDTH));
    tr_tag     = vp_tag(q_head.pc, INDEX_WIDTH);
    tr_entry   = table_q[tr_idx];
    new_stride = resolve_data - tr_entry.last;
    table_d    = table_q;
    if (res_fire) begin
      if (!tr_entry.valid || (tr_entry.tag != tr_tag)) begin
        table_d[tr_idx] = '{valid: 1'b1, tag: tr_tag, last: resolve_data,
                            stride: '0, conf: '0};
      end else begin
        if (new_stride == tr_entry.stride) begin
          if (tr_entry.conf < CONF_MAX) begin
            table_d[tr_idx].conf = tr_entry.conf + CONF_FIELD_WIDTH'(1);
          end
        end else begin
          table_d[tr_idx].stride = new_stride;
          table_d[tr_idx].conf   = '0;
        end
        table_d[tr_idx].last = resolve_data;
      end
    end

    pred_valid_d = issue && lk_pred;
    pred_value_d = (issue && lk_pred) ? lk_value : '0;
    done_d       = res_fire && !flush && q_head.pred && res_match;
    recover_d    = mispredict;
    recover_pc_d = mispredict ? q_head.pc : recover_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
      pred_valid_q <= 1'b0;
      pred_value_q <= '0;
      done_q       <= 1'b0;
      recover_q    <= 1'b0;
      recover_pc_q <= '0;
    end else begin
      table_q      <= table_d;
      pred_valid_q <= pred_valid_d;
      pred_value_q <= pred_value_d;
      done_q       <= done_d;
      recover_q    <= recover_d;
      recover_pc_q <= recover_pc_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_value = pred_value_q;
  assign done       = done_q;
  assign recover    = recover_q;
  assign recover_pc = recover_pc_q;

`ifdef VP_STATS_EN
  logic [31:0] stat_pred_q, stat_pred_d;
  logic [31:0] stat_correct_q, stat_correct_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_pred_d    = stat_pred_q + (pred_valid_d ? 32'd1 : 32'd0);
    stat_correct_d = stat_correct_q + (done_d ? 32'd1 : 32'd0);
    stat_mispred_d = stat_mispred_q + (recover_d ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred_q    <= '0;
      stat_correct_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_pred_q    <= stat_pred_d;
      stat_correct_q <= stat_correct_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_pred    = stat_pred_q;
  assign stat_correct = stat_correct_q;
  assign stat_mispred = stat_mispred_q;
`else
  assign stat_pred    = '0;
  assign stat_correct = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_stride_value_predictor.sv
// tb/tb_stride_value_predictor.sv - self-checking bench for stride_value_predictor
module tb_stride_value_predictor;

  localparam int DP = 4;
  localparam int CT = 2;
  localparam int CSAT = 3;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;
  localparam logic [31:0] Z = 32'd0;
  localparam logic [31:0] P = 32'h100;
`ifdef VP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pred_req, pred_ready, pred_valid, resolve_valid, flush, recover, done;
  logic [31:0] pred_pc, pred_value, resolve_data, recover_pc;
  logic [31:0] stat_pred, stat_correct, stat_mispred;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stride_value_predictor #(.INDEX_WIDTH(6), .CONF_WIDTH(2), .CONF_THRESH(2), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
    .pred_valid(pred_valid), .pred_value(pred_value),
    .resolve_valid(resolve_valid), .resolve_data(resolve_data), .flush(flush),
    .recover(recover), .recover_pc(recover_pc), .done(done),
    .stat_pred(stat_pred), .stat_correct(stat_correct), .stat_mispred(stat_mispred)
  );

  // ---------------- reference model (spec rules, plain arithmetic) ----------------
  typedef struct { logic [31:0] pc; bit pred; logic [31:0] val; } pend_t;
  pend_t       mq[$];
  bit          m_valid [64];
  logic [31:0] m_tag [64], m_last [64], m_stride [64];
  int          m_conf [64];
  bit          e_ready, e_pv, e_done, e_rec;
  logic [31:0] e_pval, e_rpc;
  int unsigned e_sp, e_sc, e_sm;
  bit          ready_seen;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_last[i] = 0; m_stride[i] = 0; m_conf[i] = 0;
    end
    mq.delete();
    e_ready = 0; e_pv = 0; e_done = 0; e_rec = 0; e_pval = 0; e_rpc = 0;
    e_sp = 0; e_sc = 0; e_sm = 0;
  endfunction

  function automatic void model_step(input bit req, input logic [31:0] pc, input bit rv,
                                     input logic [31:0] rd, input bit fl);
    int li, ti;
    bit fire, mis, ok, acc, hp;
    logic [31:0] pv, ns;
    pend_t h;
    h    = '{pc: 0, pred: 0, val: 0};
    li   = int'((pc >> 2) % 64);
    fire = rv && (mq.size() > 0);
    if (fire) h = mq[0];
    mis  = fire && !fl && h.pred && (h.val != rd);
    ok   = fire && !fl && h.pred && (h.val == rd);
    e_ready = (mq.size() < DP) && !mis;
    acc  = req && e_ready && !fl;
    hp   = m_valid[li] && (m_tag[li] == (pc >> 8)) && (m_conf[li] >= CT);
    pv   = m_last[li] + m_stride[li];
    if (fire) void'(mq.pop_front());
    if (fl || mis) mq.delete();
    else if (acc) mq.push_back('{pc: pc, pred: hp, val: pv});
    if (fire) begin
      ti = int'((h.pc >> 2) % 64);
      if (!m_valid[ti] || (m_tag[ti] != (h.pc >> 8))) begin
        m_valid[ti] = 1; m_tag[ti] = h.pc >> 8; m_last[ti] = rd; m_stride[ti] = 0; m_conf[ti] = 0;
      end else begin
        ns = rd - m_last[ti];
        if (ns == m_stride[ti]) m_conf[ti] = (m_conf[ti] < CSAT) ? m_conf[ti] + 1 : CSAT;
        else begin m_stride[ti] = ns; m_conf[ti] = 0; end
        m_last[ti] = rd;
      end
    end
    e_pv   = acc && hp;
    e_pval = (acc && hp) ? pv : 32'd0;
    e_done = ok;
    e_rec  = mis;
    if (mis) e_rpc = h.pc;
    if (acc && hp) e_sp++;
    if (ok) e_sc++;
    if (mis) e_sm++;
  endfunction

  function automatic logic [31:0] exp_stat(input int unsigned v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit req, input logic [31:0] pc, input bit rv,
                       input logic [31:0] rd, input bit fl);
    pred_req = req; pred_pc = pc; resolve_valid = rv; resolve_data = rd; flush = fl;
    #1;
    model_step(req, pc, rv, rd, fl);
    ready_seen = pred_ready;
    chk("pred_ready", 32'(pred_ready), 32'(e_ready));
    @(posedge clk);
    #1;
    chk("pred_valid", 32'(pred_valid), 32'(e_pv));
    chk("pred_value", pred_value, e_pval);
    chk("done", 32'(done), 32'(e_done));
    chk("recover", 32'(recover), 32'(e_rec));
    chk("recover_pc", recover_pc, e_rpc);
    chk("stat_pred", stat_pred, exp_stat(e_sp));
    chk("stat_correct", stat_correct, exp_stat(e_sc));
    chk("stat_mispred", stat_mispred, exp_stat(e_sm));
    pred_req = 0; resolve_valid = 0; flush = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pred_ready"}, 32'(pred_ready), Z);
    chk({tag, "_pred_valid"}, 32'(pred_valid), Z);
    chk({tag, "_pred_value"}, pred_value, Z);
    chk({tag, "_done"}, 32'(done), Z);
    chk({tag, "_recover"}, 32'(recover), Z);
    chk({tag, "_recover_pc"}, recover_pc, Z);
    chk({tag, "_stats"}, stat_pred | stat_correct | stat_mispred, Z);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit req; logic [31:0] pc; bit rv; logic [31:0] rd; bit fl;
    bit e_ready; bit e_pv; logic [31:0] e_pval; bit e_done; bit e_rec; logic [31:0] e_rpc;
  } vec_t;
  vec_t vt [17];

  logic [31:0] rpcs [4];
  logic [31:0] nextv [4];
  logic [31:0] strd [4];

  function automatic int pc_slot(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) if (rpcs[k] == pc) return k;
    return 0;
  endfunction

  initial begin
    vt[0]  = '{T, P, F, Z,      F, T, F, Z,      F, F, Z};
    vt[1]  = '{F, P, T, 32'd5,  F, T, F, Z,      F, F, Z};
    vt[2]  = '{T, P, F, Z,      F, T, F, Z,      F, F, Z};
    vt[3]  = '{F, P, T, 32'd9,  F, T, F, Z,      F, F, Z};
    vt[4]  = '{T, P, F, Z,      F, T, F, Z,      F, F, Z};
    vt[5]  = '{F, P, T, 32'd13, F, T, F, Z,      F, F, Z};
    vt[6]  = '{T, P, F, Z,      F, T, F, Z,      F, F, Z};
    vt[7]  = '{F, P, T, 32'd17, F, T, F, Z,      F, F, Z};
    vt[8]  = '{T, P, F, Z,      F, T, T, 32'd21, F, F, Z};
    vt[9]  = '{F, P, T, 32'd21, F, T, F, Z,      T, F, Z};
    vt[10] = '{T, P, F, Z,      F, T, T, 32'd25, F, F, Z};
    vt[11] = '{T, P, F, Z,      F, T, T, 32'd25, F, F, Z};
    vt[12] = '{T, P, F, Z,      F, T, T, 32'd25, F, F, Z};
    vt[13] = '{T, P, T, 32'd99, F, F, F, Z,      F, T, P};
    vt[14] = '{F, P, T, 32'd50, F, T, F, Z,      F, F, P};
    vt[15] = '{T, P, F, Z,      F, T, F, Z,      F, F, P};
    vt[16] = '{F, P, T, 32'd177,F, T, F, Z,      F, F, P};

    rst_n = 1; pred_req = 0; pred_pc = 0; resolve_valid = 0; resolve_data = 0; flush = 0;
    m_reset();
    #1 rst_n = 0;
    #1 chk_all_zero("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Cold training, first prediction, then a mispredict squashing the queue.
    for (int i = 0; i < 17; i++) begin
      cycle(vt[i].req, vt[i].pc, vt[i].rv, vt[i].rd, vt[i].fl);
      chk($sformatf("vec%0d_ready", i), 32'(ready_seen), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d_pred_valid", i), 32'(pred_valid), 32'(vt[i].e_pv));
      chk($sformatf("vec%0d_pred_value", i), pred_value, vt[i].e_pval);
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
      chk($sformatf("vec%0d_recover", i), 32'(recover), 32'(vt[i].e_rec));
      chk($sformatf("vec%0d_recover_pc", i), recover_pc, vt[i].e_rpc);
    end

    // Fill the queue; a resolve with a request while not full keeps occupancy.
    repeat (4) cycle(T, 32'h30C, F, Z, F);
    cycle(T, 32'h30C, F, Z, F);
    chk("full_ready", 32'(ready_seen), Z);
    chk("full_no_pred", 32'(pred_valid), Z);
    cycle(F, Z, T, 32'd1, F);
    cycle(T, 32'h30C, T, 32'd2, F);
    chk("pop_push_ready", 32'(ready_seen), 32'd1);
    cycle(T, 32'h30C, F, Z, F);
    cycle(T, 32'h30C, F, Z, F);
    chk("occupancy_kept", 32'(ready_seen), Z);
    for (int i = 0; i < 4; i++) cycle(F, Z, T, 32'(3 + i), F);

    // Aliasing PCs on the same index never build confidence.
    for (int k = 0; k < 4; k++) begin
      cycle(T, 32'h200, F, Z, F);
      chk("alias_200_nopred", 32'(pred_valid), Z);
      cycle(F, Z, T, 32'(10 * k), F);
      cycle(T, 32'h100, F, Z, F);
      chk("alias_100_nopred", 32'(pred_valid), Z);
      cycle(F, Z, T, 32'(7 * k), F);
    end

    // Wrap-around of last + stride.
    for (int i = 0; i < 6; i++) begin
      cycle(T, 32'h404, F, Z, F);
      cycle(F, Z, T, 32'hFFFF_FFEA + 32'(4 * i), F);
    end
    cycle(T, 32'h404, F, Z, F);
    chk("wrap_valid", 32'(pred_valid), 32'd1);
    chk("wrap_value", pred_value, 32'h0000_0002);

    // Flush with a same-cycle request; table survives.
    cycle(T, 32'h404, F, Z, F);
    cycle(T, 32'h404, F, Z, F);
    cycle(T, 32'h404, F, Z, T);
    chk("flush_no_pred", 32'(pred_valid), Z);
    cycle(F, Z, T, 32'd2, F);
    chk("flush_empty_no_done", 32'(done), Z);
    cycle(T, 32'h404, F, Z, F);
    chk("flush_table_kept", pred_value, 32'h0000_0002);
    cycle(F, Z, T, 32'd2, F);
    chk("flush_then_done", 32'(done), 32'd1);

    // Asynchronous reset mid-stream.
    cycle(T, 32'h404, F, Z, F);
    cycle(T, 32'h404, F, Z, F);
    #2 rst_n = 0;
    #1 chk_all_zero("midreset");
    @(negedge clk); rst_n = 1;
    m_reset();
    @(posedge clk); #1;

    // Randomized traffic against the model.
    rpcs[0] = 32'h100; rpcs[1] = 32'h200; rpcs[2] = 32'h104; rpcs[3] = 32'h30C;
    strd[0] = 32'd4;   strd[1] = 32'd8;   strd[2] = 32'd0;   strd[3] = 32'hFFFF_FFF4;
    for (int k = 0; k < 4; k++) nextv[k] = $urandom;
    for (int i = 0; i < 600; i++) begin
      bit r_req, r_rv, r_fl;
      int k;
      logic [31:0] d, pc;
      r_req = ($urandom_range(0, 1) == 1);
      r_rv  = ($urandom_range(0, 1) == 1);
      r_fl  = ($urandom_range(0, 39) == 0);
      pc    = rpcs[$urandom_range(0, 3)];
      d     = $urandom;
      if (r_rv && mq.size() > 0) begin
        k = pc_slot(mq[0].pc);
        if ($urandom_range(0, 7) != 0) d = nextv[k];
        nextv[k] = nextv[k] + strd[k];
      end
      cycle(r_req, pc, r_rv, d, r_fl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
